// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard information from the ID/EX stages and the pipeline-register
// enables returned by hazard_ctrl.
//   master : pipeline side, drives hazard information, receives enables/status
//   slave  : hazard_ctrl side
// Signals:
//   ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2  ID instruction source operands
//   EX_RD, EX_REG_EN, EX_IS_LOAD, EX_IS_DIV   EX instruction destination/kind
//   EX_BRANCH_TAKEN                           taken branch/jump resolved in EX
//   STALL_PC, STALL_IF_ID, FLUSH_IF_ID,
//   STALL_ID_EX, FLUSH_ID_EX, BUBBLE_EX_MA    pipeline-register enables
//   DIV_START                                 one-cycle divider start pulse
//   STATE                                     RUN=00, DIV_BUSY=10, FLUSH=11
//   STALL_COUNT                               cycles with STALL_PC=1 (wraps)
interface hazard_ctrl_if;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic        ID_USES_RS1;
    logic        ID_USES_RS2;
    logic [4:0]  EX_RD;
    logic        EX_REG_EN;
    logic        EX_IS_LOAD;
    logic        EX_IS_DIV;
    logic        EX_BRANCH_TAKEN;
    logic        STALL_PC;
    logic        STALL_IF_ID;
    logic        FLUSH_IF_ID;
    logic        STALL_ID_EX;
    logic        FLUSH_ID_EX;
    logic        BUBBLE_EX_MA;
    logic        DIV_START;
    logic [1:0]  STATE;
    logic [31:0] STALL_COUNT;

    modport master (
        output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        output EX_RD, EX_REG_EN, EX_IS_LOAD, EX_IS_DIV, EX_BRANCH_TAKEN,
        input  STALL_PC, STALL_IF_ID, FLUSH_IF_ID, STALL_ID_EX, FLUSH_ID_EX,
        input  BUBBLE_EX_MA, DIV_START, STATE, STALL_COUNT
    );

    modport slave (
        input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        input  EX_RD, EX_REG_EN, EX_IS_LOAD, EX_IS_DIV, EX_BRANCH_TAKEN,
        output STALL_PC, STALL_IF_ID, FLUSH_IF_ID, STALL_ID_EX, FLUSH_ID_EX,
        output BUBBLE_EX_MA, DIV_START, STATE, STALL_COUNT
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage core. Resolves load-use
// stalls, multi-cycle divide occupancy of EX and taken-branch redirect bubbles, and counts
// stalled cycles. MA/WB is never stalled.
// Parameters:
//   DIV_LATENCY    stall cycles charged to a divide in EX (1..255)
//   REDIRECT_EXTRA extra IF/ID flush cycles after a taken branch (0..7)
// Ports:
//   CLK      rising-edge clock
//   RESET_N  asynchronous active-low reset; forces every enable to 0 while low
//   bus      hazard_ctrl_if slave modport (hazard inputs, enables, STATE, STALL_COUNT)
module hazard_ctrl #(
    parameter int unsigned DIV_LATENCY    = 33,
    parameter int unsigned REDIRECT_EXTRA = 1
) (
    input logic         CLK,
    input logic         RESET_N,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StDivBusy = 2'b10,
        StFlush   = 2'b11
    } state_e;

    localparam logic [7:0] DivCntInit   = 8'(DIV_LATENCY - 1);
    localparam logic [7:0] FlushCntInit = (REDIRECT_EXTRA > 0) ? 8'(REDIRECT_EXTRA - 1) : 8'd0;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] stall_count_q;

    logic load_use;
    logic stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex, bubble_ex_ma;
    logic div_start;

    assign load_use = bus.EX_IS_LOAD & bus.EX_REG_EN & (bus.EX_RD != 5'd0) &
                      ((bus.ID_USES_RS1 & (bus.ID_RS1 == bus.EX_RD)) |
                       (bus.ID_USES_RS2 & (bus.ID_RS2 == bus.EX_RD)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        flush_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_id_ex  = 1'b0;
        bubble_ex_ma = 1'b0;
        div_start    = 1'b0;
        unique case (state_q)
            StRun: begin
                // Priority: divide, then branch, then load-use.
                if (bus.EX_IS_DIV) begin
                    div_start    = 1'b1;
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    bubble_ex_ma = 1'b1;
                    cnt_d        = DivCntInit;
                    state_d      = StDivBusy;
                end else if (bus.EX_BRANCH_TAKEN) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    if (REDIRECT_EXTRA > 0) begin
                        cnt_d   = FlushCntInit;
                        state_d = StFlush;
                    end
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            StDivBusy: begin
                // CNT==0 is the release cycle: EX/MA captures the divide result.
                if (cnt_q != 8'd0) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    stall_id_ex  = 1'b1;
                    bubble_ex_ma = 1'b1;
                    cnt_d        = cnt_q - 8'd1;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                flush_if_id = 1'b1;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= StRun;
            cnt_q         <= 8'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_pc) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    // Reset forces the enables low even though RUN decodes them from live inputs.
    assign bus.STALL_PC     = RESET_N & stall_pc;
    assign bus.STALL_IF_ID  = RESET_N & stall_if_id;
    assign bus.FLUSH_IF_ID  = RESET_N & flush_if_id;
    assign bus.STALL_ID_EX  = RESET_N & stall_id_ex;
    assign bus.FLUSH_ID_EX  = RESET_N & flush_id_ex;
    assign bus.BUBBLE_EX_MA = RESET_N & bubble_ex_ma;
    assign bus.DIV_START    = RESET_N & div_start;
    assign bus.STATE        = state_q;
    assign bus.STALL_COUNT  = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed stimulus for hazard_ctrl, checked every cycle
// against a cycle-window model (divide and redirect windows tracked by start cycle).
module tb_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int EXTRA = 1;

    logic CLK;
    logic RESET_N;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .DIV_LATENCY    (LAT),
        .REDIRECT_EXTRA (EXTRA)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    // Model: cycle index, start cycle of the last accepted divide / redirect, stall total.
    int          cyc    = 0;
    int          div_t  = -100;
    int          fl_t   = -100;
    logic [31:0] m_count = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {STALL_PC, STALL_IF_ID, FLUSH_IF_ID, STALL_ID_EX, FLUSH_ID_EX, BUBBLE_EX_MA, DIV_START}
    function automatic logic [6:0] enables();
        return {bus.STALL_PC, bus.STALL_IF_ID, bus.FLUSH_IF_ID, bus.STALL_ID_EX,
                bus.FLUSH_ID_EX, bus.BUBBLE_EX_MA, bus.DIV_START};
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic reg_en,
                         input logic load, input logic div, input logic br);
        bus.ID_RS1          = rs1;
        bus.ID_RS2          = rs2;
        bus.ID_USES_RS1     = u1;
        bus.ID_USES_RS2     = u2;
        bus.EX_RD           = rd;
        bus.EX_REG_EN       = reg_en;
        bus.EX_IS_LOAD      = load;
        bus.EX_IS_DIV       = div;
        bus.EX_BRANCH_TAKEN = br;
    endtask

    task automatic model_reset();
        div_t   = -100;
        fl_t    = -100;
        m_count = 32'd0;
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic reg_en,
                        input logic load, input logic div, input logic br);
        logic [6:0] e;
        logic [1:0] es;
        logic       lu;
        @(negedge CLK);
        drive(rs1, rs2, u1, u2, rd, reg_en, load, div, br);
        #1;
        e  = 7'b0;
        lu = load && reg_en && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (cyc > div_t && cyc <= div_t + LAT) begin
            es = 2'b10;
            if (cyc < div_t + LAT) e = 7'b1101010;
        end else if (cyc > fl_t && cyc <= fl_t + EXTRA) begin
            es = 2'b11;
            e  = 7'b0010000;
        end else begin
            es = 2'b00;
            if (div) begin
                e     = 7'b1101011;
                div_t = cyc;
            end else if (br) begin
                e    = 7'b0010100;
                fl_t = cyc;
            end else if (lu) begin
                e = 7'b1100100;
            end
        end
        check_eq("enables", {25'd0, enables()}, {25'd0, e});
        check_eq("state", {30'd0, bus.STATE}, {30'd0, es});
        check_eq("stall_count", bus.STALL_COUNT, m_count);
        if (e[6]) m_count = m_count + 32'd1;
        cyc++;
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lu_step();
        step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] c0;
        RESET_N = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #2;
        check_eq("reset_state", {30'd0, bus.STATE}, 32'd0);
        check_eq("reset_count", bus.STALL_COUNT, 32'd0);
        check_eq("reset_enables", {25'd0, enables()}, 32'd0);
        RESET_N = 1'b1;
        model_reset();

        // Load-use, then the same with EX_RD=x0.
        idle();
        lu_step();
        idle();
        check_eq("lu_count", bus.STALL_COUNT, 32'd1);
        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        check_eq("lu_x0_count", bus.STALL_COUNT, 32'd1);

        // Divide held in EX for LAT+1 cycles.
        c0 = m_count;
        repeat (LAT + 1) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        check_eq("div_count", bus.STALL_COUNT, c0 + 32'd4);

        // Taken branch, branch+LU, divide+branch, back-to-back divides.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        idle();
        repeat (2 * (LAT + 1)) step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        idle();

        // Randomized traffic; small register range gives frequent matches.
        for (int i = 0; i < 1500; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 5) == 0));
        end
        repeat (LAT + 2) idle();

        // Reset in the middle of a divide.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        RESET_N = 1'b0;
        #1;
        check_eq("midrst_enables", {25'd0, enables()}, 32'd0);
        check_eq("midrst_state", {30'd0, bus.STATE}, 32'd0);
        check_eq("midrst_count", bus.STALL_COUNT, 32'd0);
        @(posedge CLK);
        #2;
        check_eq("rst_hold_enables", {25'd0, enables()}, 32'd0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        RESET_N = 1'b1;
        model_reset();
        idle();
        lu_step();
        idle();

        // Counter wrap: preload near the top, then three stall cycles.
        idle();
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        m_count = 32'hFFFF_FFFE;
        repeat (3) lu_step();
        idle();
        check_eq("wrap_count", bus.STALL_COUNT, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the RV32IM five-stage core. Watches ID and EX stage hazard information and drives the stall, flush and bubble enables for the PC, IF/ID, ID/EX and EX/MA registers. It resolves three cases: load-use stalls, multi-cycle divide occupancy of EX, and taken-branch redirect bubbles. The MA/WB register is never stalled, so older instructions always drain to writeback. A 32-bit stall-cycle counter is kept for performance monitoring.

## Interface
- DIV_LATENCY, 33: stall cycles charged to a DIV/DIVU/REM/REMU in EX; legal range 1..255.
- REDIRECT_EXTRA, 1: extra IF/ID flush cycles after a taken branch, covering instruction-memory read latency; legal range 0..7.
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ID_RS1, ID_RS2  in  5 each  source register indices of the instruction in ID.
- ID_USES_RS1, ID_USES_RS2  in  1 each  the ID instruction reads that source.
- EX_RD  in  5  destination register of the instruction in EX.
- EX_REG_EN  in  1  the EX instruction writes the register file.
- EX_IS_LOAD  in  1  the EX instruction is a load.
- EX_IS_DIV  in  1  the EX instruction is a divide or remainder.
- EX_BRANCH_TAKEN  in  1  a taken branch or jump is resolved in EX this cycle.
- STALL_PC  out  1  hold the PC.
- STALL_IF_ID  out  1  hold the IF/ID register.
- FLUSH_IF_ID  out  1  load a bubble into IF/ID.
- STALL_ID_EX  out  1  hold the ID/EX register.
- FLUSH_ID_EX  out  1  load a bubble into ID/EX.
- BUBBLE_EX_MA  out  1  load a bubble into EX/MA (REG_EN=0, no memory access).
- DIV_START  out  1  one-cycle start pulse to the divider.
- STATE  out  2  current state: RUN=00, DIV_BUSY=10, FLUSH=11; 01 is unused.
- STALL_COUNT  out  32  number of cycles with STALL_PC=1; wraps.

## Operation
- State and the down-counter CNT (8 bits) are registered. All enable outputs are combinational from state, CNT and the inputs.
- Load-use condition LU = EX_IS_LOAD & EX_REG_EN & (EX_RD≠0) & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
- RUN, evaluated in priority order:
  1. EX_IS_DIV: assert DIV_START, STALL_PC, STALL_IF_ID, STALL_ID_EX and BUBBLE_EX_MA. Load CNT with DIV_LATENCY-1. Next state is DIV_BUSY. Any branch or LU in the same cycle is ignored.
  2. EX_BRANCH_TAKEN: assert FLUSH_IF_ID and FLUSH_ID_EX. The PC is not stalled. If REDIRECT_EXTRA>0, load CNT with REDIRECT_EXTRA-1 and go to FLUSH; otherwise stay in RUN. LU is ignored.
  3. LU: assert STALL_PC, STALL_IF_ID and FLUSH_ID_EX for this cycle only. Stay in RUN.
  4. Otherwise all enables are 0.
- DIV_BUSY:
  - CNT≠0: assert STALL_PC, STALL_IF_ID, STALL_ID_EX and BUBBLE_EX_MA; decrement CNT.
  - CNT==0: all enables 0, so the divide result is captured by EX/MA; next state is RUN.
  - Branch and LU inputs are ignored throughout DIV_BUSY.
- FLUSH:
  - Assert FLUSH_IF_ID only. All EX and ID hazard inputs are ignored.
  - CNT≠0: decrement CNT. CNT==0: next state is RUN.
- STALL_COUNT increments on every rising edge where STALL_PC=1. It wraps from 0xFFFFFFFF to 0.
- A stall and a flush of the same register are never asserted together.

## Timing
- Reset (RESET_N=0, asynchronous): STATE=RUN, CNT=0, STALL_COUNT=0. While RESET_N=0, every enable output and DIV_START is forced to 0 regardless of inputs. An assertion mid-divide or mid-flush aborts the operation immediately.
- Load-use costs exactly 1 bubble. Next cycle the load is in MA and LU is false.
- A divide entering EX at cycle T:
  - Stalls are asserted in T..T+DIV_LATENCY-1.
  - Release happens in cycle T+DIV_LATENCY.
  - The instruction occupies EX for DIV_LATENCY+1 cycles.
  - DIV_START is high only in T.
- A taken branch at cycle T: FLUSH_IF_ID is high in T..T+REDIRECT_EXTRA, and FLUSH_ID_EX only in T.
- Back-to-back divides: the second divide enters EX the cycle after release and is detected in RUN again, with no idle cycle between them.

## Test plan
- Load x5 in EX, ID reads rs2=x5 with ID_USES_RS2=1 -> STALL_PC=STALL_IF_ID=FLUSH_ID_EX=1 for 1 cycle, STALL_COUNT=1. Same test with EX_RD=0 -> no stall.
- DIV in EX with DIV_LATENCY=4 -> DIV_START high 1 cycle; stalls and BUBBLE_EX_MA high 4 cycles; STATE=10 for cycles 2-5; release in cycle 5; STALL_COUNT=4.
- Taken branch with REDIRECT_EXTRA=1 -> FLUSH_IF_ID high 2 cycles, FLUSH_ID_EX high 1 cycle, STALL_PC never high, STATE=11 for 1 cycle.
- Branch taken plus LU in the same cycle -> flush only, no stall; DIV plus branch -> divide sequence only.
- RESET_N pulsed low during DIV_BUSY with CNT=10 -> outputs 0 immediately; STATE=00 and STALL_COUNT=0 after release.
- Preload STALL_COUNT near wrap (run 2^32-2 stall cycles, or force) then 3 stall cycles -> value 1.
